fifo_load_seq: RTL and testbench
================================

Name: fifo_load_seq

Overview:
- Parametrised sequencer that moves NCH channel words per ADC sample into a shared readout FIFO.
- Sample count per burst is programmable, with FIFO backpressure.
- Drives the channel mux select (SEL) and FIFO write enable (WRENA) for one burst of SAMP_MAX+1 samples per START.
- Sits between the sample buffer mux and the readout FIFO. Generalises the fixed 6-channel loader with channel count, counter width, backpressure, restart and status outputs.

Parameters:
- NCH, 6, channels (words) per sample; legal range 2..64.
- SAMP_W, 7, width of the sample counter and SAMP_MAX.
- SEL_W, $clog2(NCH), derived localparam; never overridden.

Ports:
- CLK  in  1  clock
- RST  in  1  reset; asynchronous, active-high
- START  in  1  single-cycle burst request; also restarts a running burst
- SAMP_MAX  in  SAMP_W  index of last sample in burst; captured on START
- FULL  in  1  FIFO cannot accept a write on the next cycle (prog-full, margin of 1)
- SEL  out  SEL_W  channel select for the word presented this cycle
- WRENA  out  1  FIFO write strobe; word at SEL is written when high
- SAMPLE  out  SAMP_W  current sample index
- BUSY  out  1  burst in progress
- DONE  out  1  one-cycle pulse after the last word of a burst

Behaviour:
- Reset values: SEL=0, WRENA=0, SAMPLE=0, BUSY=0, DONE=0, state IDLE, latched max=0.
- All outputs are registered. Outputs are decoded from the next state, so they are valid in the same cycle as the state they describe.
- States:
  - IDLE
  - RST_SAMP: first word of sample 0, SEL=0.
  - XFER: SEL=1..NCH-1.
  - NXT_SAMP: SEL=0, SAMPLE+1.
  - STALL: WRENA=0, SEL/SAMPLE frozen; the state to resume is held in a return register.
- IDLE + START -> RST_SAMP: max_q<=SAMP_MAX, SAMPLE=0, SEL=0, WRENA=1, BUSY=1. First write occurs 1 cycle after START.
- RST_SAMP/NXT_SAMP -> XFER with SEL=1.
- XFER, SEL<NCH-1 -> XFER with SEL+1.
- XFER, SEL==NCH-1:
  - If SAMPLE==max_q -> IDLE: WRENA=0, BUSY=0, DONE=1 for one cycle, SEL=0, SAMPLE=0.
  - Otherwise -> NXT_SAMP.
- Throughput: exactly NCH*(max_q+1) contiguous writes when FULL stays low; no bubbles between samples.
- FULL high at a clock edge while BUSY:
  - Transitions to STALL. The word advance is suppressed, WRENA=0, SEL/SAMPLE hold.
  - The word presented in the cycle FULL was seen counts as written.
  - When FULL is low, resumes at the next word with WRENA=1. No word is lost or duplicated.
- START while BUSY (any state, including STALL) has priority over FULL and advance:
  - Restart into RST_SAMP with new SAMP_MAX.
  - If FULL is also high, counters reset but WRENA=0 (STALL, return=RST_SAMP).
  - DONE is not pulsed for the aborted burst.
- START in the same cycle as final word: restart wins, no DONE.
- SAMP_MAX=0: one sample, NCH writes. SAMP_MAX=2^SAMP_W-1 is legal; the counter never wraps.
- Changes on SAMP_MAX after START are ignored.
- FULL in IDLE is ignored.
- Unreachable state encodings recover to IDLE on the next edge.

Optional Feature:
- Macro FIFO_LOAD_SEQ_TMR_EN.
- When defined:
  - State, return register, SEL, WRENA, SAMPLE, max_q, BUSY and DONE are triplicated.
  - Each copy's next-state/next-value logic reads majority-voted values.
  - Outputs are voted. Copies carry syn_preserve and voted nets carry syn_keep.
  - A single-copy upset is corrected within one clock with no output glitch.
- When undefined: single copy, identical cycle behaviour.

Decomposition:
- Package fifo_load_pkg:
  - State encoding constants IDLE/RST_SAMP/XFER/NXT_SAMP/STALL (3 bits).
  - Majority-vote function vote3.
- Sub-module tmr_voter #(W): three W-bit inputs, one voted output. Used only under FIFO_LOAD_SEQ_TMR_EN.

Test Plan:
- NCH=6, SAMP_MAX=2, START pulse, FULL=0 -> 18 consecutive WRENA cycles starting 1 cycle after START. SEL 0..5 repeated with SAMPLE 0,1,2; DONE pulse on cycle 19; BUSY 18 cycles.
- Same burst, FULL high for 3 edges while SEL=3 presented -> WRENA low 3 cycles. Resumes at SEL=4; total writes still 18, no duplicates.
- START again at SAMPLE=1, SEL=2 with SAMP_MAX=0 -> next cycle SEL=0, SAMPLE=0. 6 writes then DONE; no DONE for the aborted burst.
- SAMP_MAX=0, NCH=2 -> exactly 2 writes (SEL 0,1) then DONE. SAMP_W=3, SAMP_MAX=7 -> 8*NCH writes, SAMPLE reaches 7 without wrap.
- RST asserted mid-burst at SEL=4 -> all outputs 0 immediately (async). After release, idle until next START.
- With FIFO_LOAD_SEQ_TMR_EN: force one copy of state to XFER during IDLE, and one SAMPLE copy bit flipped mid-burst -> outputs unchanged, copy re-converges after 1 cycle.

Source files
------------

// File: rtl/fifo_load_seq_pkg.sv
// fifo_load_pkg: state encoding and majority-vote helper shared by the FIFO load sequencer
package fifo_load_pkg;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RST_SAMP = 3'd1,
    XFER     = 3'd2,
    NXT_SAMP = 3'd3,
    STALL    = 3'd4
  } state_t;
  function automatic logic vote3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/fifo_load_seq_if.sv
// fifo_load_seq_if: burst request, FIFO backpressure and channel-mux/write-strobe bundle
interface fifo_load_seq_if #(parameter int NCH = 6, parameter int SAMP_W = 7);
  localparam int SEL_W = $clog2(NCH);
  logic              START;
  logic [SAMP_W-1:0] SAMP_MAX;
  logic              FULL;
  logic [SEL_W-1:0]  SEL;
  logic              WRENA;
  logic [SAMP_W-1:0] SAMPLE;
  logic              BUSY;
  logic              DONE;
  modport master(output START, SAMP_MAX, FULL, input SEL, WRENA, SAMPLE, BUSY, DONE);
  modport slave(input START, SAMP_MAX, FULL, output SEL, WRENA, SAMPLE, BUSY, DONE);
endinterface

// File: rtl/fifo_load_seq_tmr_voter.sv
// tmr_voter: bitwise 2-of-3 majority across three W-bit copies
module tmr_voter import fifo_load_pkg::*; #(parameter int W = 1) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] y
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign y[i] = vote3(a[i], b[i], c[i]);
  end
endmodule

// File: rtl/fifo_load_seq.sv
// fifo_load_seq: moves NCH words per sample into the readout FIFO; FIFO_LOAD_SEQ_TMR_EN triplicates all state
module fifo_load_seq import fifo_load_pkg::*; #(
  parameter int NCH    = 6,
  parameter int SAMP_W = 7
) (
  input logic           CLK,
  input logic           RST,
  fifo_load_seq_if.slave bus
);
  localparam int SEL_W = $clog2(NCH);
  typedef struct packed {
    state_t            st;
    state_t            ret;
    logic [SEL_W-1:0]  sel;
    logic              wrena;
    logic [SAMP_W-1:0] sample;
    logic [SAMP_W-1:0] max_q;
    logic              busy;
    logic              done;
  } regs_t;
  regs_t  cur;
  regs_t  nxt;
  logic   last;
  state_t adv;
  state_t tgt;
  // next register image: restart beats backpressure beats advance; sel/sample hold the last written word while stalled
  always_comb begin
    last = cur.sel == SEL_W'(NCH - 1);
    adv  = !last ? XFER : (cur.sample == cur.max_q ? IDLE : NXT_SAMP);
    tgt  = cur.st == STALL ? cur.ret : adv;
    nxt  = cur;
    nxt.done = 1'b0;
    if (bus.START) begin
      nxt.st     = (bus.FULL && cur.busy) ? STALL : RST_SAMP;
      nxt.ret    = RST_SAMP;
      nxt.sel    = '0;
      nxt.sample = '0;
      nxt.max_q  = bus.SAMP_MAX;
      nxt.wrena  = !(bus.FULL && cur.busy);
      nxt.busy   = 1'b1;
    end else if (cur.st inside {RST_SAMP, XFER, NXT_SAMP, STALL}) begin
      if (bus.FULL) begin
        nxt.st    = STALL;
        nxt.ret   = tgt;
        nxt.wrena = 1'b0;
      end else begin
        nxt.st     = tgt inside {RST_SAMP, XFER, NXT_SAMP} ? tgt : IDLE;
        nxt.sel    = tgt == XFER ? cur.sel + 1'b1 : '0;
        nxt.sample = tgt == XFER ? cur.sample : tgt == NXT_SAMP ? cur.sample + 1'b1 : '0;
        nxt.wrena  = tgt inside {RST_SAMP, XFER, NXT_SAMP};
        nxt.busy   = tgt inside {RST_SAMP, XFER, NXT_SAMP};
        nxt.done   = tgt == IDLE;
      end
    end else begin
      nxt       = '0;
      nxt.max_q = cur.max_q;
    end
  end
`ifdef FIFO_LOAD_SEQ_TMR_EN
  (* syn_preserve = 1 *) regs_t [2:0] cp;
  (* syn_keep = 1 *) regs_t voted;
  tmr_voter #(.W($bits(regs_t))) u_vote (.a(cp[0]), .b(cp[1]), .c(cp[2]), .y(voted));
  assign cur = voted;
  // three copies all load the image computed from the voted state, so a single upset heals in one edge
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cp <= '0;
    else     cp <= {nxt, nxt, nxt};
  end
`else
  // single register copy of the whole sequencer state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cur <= '0;
    else     cur <= nxt;
  end
`endif
  assign bus.SEL    = cur.sel;
  assign bus.WRENA  = cur.wrena;
  assign bus.SAMPLE = cur.sample;
  assign bus.BUSY   = cur.busy;
  assign bus.DONE   = cur.done;
endmodule

// File: tb/tb_fifo_load_seq.sv
// tb_fifo_load_seq: word-index reference model driving a 6-channel/7-bit and a 2-channel/3-bit sequencer in lockstep
module tb_fifo_load_seq;
  import fifo_load_pkg::*;
  logic clk;
  logic rst;
  logic start;
  logic full;
  logic [6:0] smax;
  int total;
  int bad;
  int wa;
  int wb;
  int nchs [2] = '{6, 2};
  int n [2];
  int tot [2];
  int w [2];
  bit act [2];
  bit wr [2];
  bit dn [2];
  fifo_load_seq_if #(.NCH(6), .SAMP_W(7)) ia ();
  fifo_load_seq_if #(.NCH(2), .SAMP_W(3)) ib ();
  assign ia.START = start;
  assign ia.FULL = full;
  assign ia.SAMP_MAX = smax;
  assign ib.START = start;
  assign ib.FULL = full;
  assign ib.SAMP_MAX = smax[2:0];
  fifo_load_seq #(.NCH(6), .SAMP_W(7)) dut_a (.CLK(clk), .RST(rst), .bus(ia.slave));
  fifo_load_seq #(.NCH(2), .SAMP_W(3)) dut_b (.CLK(clk), .RST(rst), .bus(ib.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      n[i] = 0; tot[i] = 0; w[i] = 0; act[i] = 0; wr[i] = 0; dn[i] = 0;
    end
  endtask
  task automatic step(input int i);
    int m;
    m = i == 0 ? int'(smax) : int'(smax & 7'd7);
    if (start) begin
      wr[i] = !(full && act[i]);
      n[i] = wr[i] ? 1 : 0;
      act[i] = 1; tot[i] = nchs[i] * (m + 1); w[i] = 0; dn[i] = 0;
    end else if (act[i]) begin
      dn[i] = 0;
      if (full) wr[i] = 0;
      else if (n[i] == tot[i]) begin
        act[i] = 0; dn[i] = 1; wr[i] = 0; w[i] = 0;
      end else begin
        wr[i] = 1; w[i] = n[i]; n[i]++;
      end
    end else begin
      dn[i] = 0; wr[i] = 0;
    end
  endtask
  task automatic check_all();
    chk("a_sel", 32'(ia.SEL), w[0] % 6);
    chk("a_sample", 32'(ia.SAMPLE), w[0] / 6);
    chk("a_wrena", 32'(ia.WRENA), 32'(wr[0]));
    chk("a_busy", 32'(ia.BUSY), 32'(act[0]));
    chk("a_done", 32'(ia.DONE), 32'(dn[0]));
    chk("b_sel", 32'(ib.SEL), w[1] % 2);
    chk("b_sample", 32'(ib.SAMPLE), w[1] / 2);
    chk("b_wrena", 32'(ib.WRENA), 32'(wr[1]));
    chk("b_busy", 32'(ib.BUSY), 32'(act[1]));
    chk("b_done", 32'(ib.DONE), 32'(dn[1]));
  endtask
  task automatic cyc(input bit s, input bit f, input logic [6:0] m);
    start = s; full = f; smax = m;
    @(posedge clk);
    if (rst) mreset();
    else begin
      step(0); step(1);
    end
    #2;
    check_all();
    if (ia.WRENA) wa++;
    if (ib.WRENA) wb++;
  endtask
  initial begin
    total = 0; bad = 0; wa = 0; wb = 0;
    rst = 1'b1; start = 1'b0; full = 1'b0; smax = '0;
    mreset();
    #3;
    check_all();
    cyc(0, 1, 0);
    rst = 1'b0;
    repeat (2) cyc(0, 1, 5);
    wa = 0;
    cyc(1, 0, 2);
    repeat (19) cyc(0, 0, 0);
    chk("burst_writes", wa, 18);
    wa = 0;
    cyc(1, 0, 2);
    repeat (3) cyc(0, 0, 0);
    repeat (3) cyc(0, 1, 0);
    repeat (20) cyc(0, 0, 0);
    chk("stall_writes", wa, 18);
    cyc(1, 0, 2);
    repeat (8) cyc(0, 0, 0);
    wa = 0;
    cyc(1, 0, 0);
    repeat (8) cyc(0, 0, 3);
    chk("restart_writes", wa, 6);
    cyc(1, 0, 3);
    repeat (4) cyc(0, 0, 0);
    cyc(1, 1, 1);
    cyc(0, 1, 1);
    repeat (15) cyc(0, 0, 0);
    wa = 0; wb = 0;
    cyc(1, 0, 7);
    repeat (52) cyc(0, 0, 0);
    chk("a_max7_writes", wa, 48);
    chk("b_max7_writes", wb, 16);
    wb = 0;
    cyc(1, 0, 0);
    repeat (7) cyc(0, 0, 0);
    chk("b_max0_writes", wb, 2);
    cyc(1, 0, 0);
    repeat (5) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (8) cyc(0, 0, 0);
    cyc(1, 0, 2);
    repeat (4) cyc(0, 0, 0);
    rst = 1'b1;
    #1;
    mreset();
    check_all();
    cyc(0, 0, 0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) cyc(0, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)));
`ifdef FIFO_LOAD_SEQ_TMR_EN
    begin
      logic [6:0] flip;
      force dut_a.cp[1].st = XFER;
      #1;
      release dut_a.cp[1].st;
      check_all();
      cyc(0, 0, 0);
      chk("tmr_state_conv", 32'(dut_a.cp[1].st), 32'(IDLE));
      cyc(1, 0, 2);
      repeat (7) cyc(0, 0, 0);
      flip = dut_a.cp[2].sample ^ 7'd1;
      force dut_a.cp[2].sample = flip;
      #1;
      release dut_a.cp[2].sample;
      check_all();
      cyc(0, 0, 0);
      chk("tmr_sample_conv", 32'(dut_a.cp[2].sample), 32'(dut_a.cp[0].sample));
      repeat (15) cyc(0, 0, 0);
    end
`endif
    for (int k = 0; k < 500; k++)
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0, 7'($urandom_range(0, 7)));
    repeat (60) cyc(0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
